// File: rtl/icomp_pkg.sv
// icomp_pkg: shared constants, state encoding and helpers for the identity
// comparator decoder. Pair count and counter widths are derived here so the
// top and the pair walker size their counters identically.
`timescale 1ns/1ps
package icomp_pkg;

  // Bit positions inside one lt/eq/gt triple
  localparam int TRI_LT = 0;
  localparam int TRI_EQ = 1;
  localparam int TRI_GT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } icomp_dec_state_e;

  // Number of unordered bit pairs in a w-bit word
  function automatic int npairs(input int w);
    return w * (w - 1) / 2;
  endfunction

  // Counter width able to index n items, never narrower than one bit
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Legal comparator triple for the ordered bit pair (a, b)
  function automatic logic [2:0] exp_triple(input bit a, input bit b);
    logic [2:0] t;
    t = 3'b000;
    if (a == b) t[TRI_EQ] = 1'b1;
    else if (!a) t[TRI_LT] = 1'b1;
    else t[TRI_GT] = 1'b1;
    return t;
  endfunction

endpackage

// File: rtl/icomp_pair_walker.sv
// icomp_pair_walker: enumerates bit pairs (j,i), j<i, in j-major order with a
// linear pair index k. Restarts at (0,1) on start, advances on step, and
// parks on the last pair instead of wrapping.
`timescale 1ns/1ps
module icomp_pair_walker
  import icomp_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int KW    = cnt_bits(npairs(WIDTH)),
  parameter int JW    = cnt_bits(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          step,
  output logic [KW-1:0] k,
  output logic [JW-1:0] j,
  output logic [JW-1:0] i,
  output logic          last
);

  localparam int P = npairs(WIDTH);

  logic [KW-1:0] k_q, k_d;
  logic [JW-1:0] j_q, j_d;
  logic [JW-1:0] i_q, i_d;

  assign k    = k_q;
  assign j    = j_q;
  assign i    = i_q;
  assign last = (k_q == KW'(P - 1));

  // Next pair: restart on start, otherwise advance until the last pair
  always_comb begin
    k_d = k_q;
    j_d = j_q;
    i_d = i_q;
    if (start) begin
      k_d = '0;
      j_d = '0;
      i_d = JW'(1);
    end else if (step && !last) begin
      k_d = k_q + 1'b1;
      if (i_q == JW'(WIDTH - 1)) begin
        j_d = j_q + 1'b1;
        i_d = j_q + JW'(2);
      end else begin
        i_d = i_q + 1'b1;
      end
    end
  end

  // Pair position registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
      j_q <= '0;
      i_q <= JW'(1);
    end else begin
      k_q <= k_d;
      j_q <= j_d;
      i_q <= i_d;
    end
  end

endmodule

// File: rtl/icomp_decoder.sv
// icomp_decoder: sequential inverse of the identity comparator. Walks one
// pair per cycle, rebuilding r = A xor A[0] from the j=0 pairs, learning the
// A[0] polarity from the first lt/gt, and cross-checking every j>0 pair.
// Optional build macro ICOMP_DEC_EARLY_ABORT_EN: jump to DONE on the first
// cycle that detects an error instead of scanning the remaining pairs.
`timescale 1ns/1ps
module icomp_decoder
  import icomp_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [3*npairs(WIDTH)-1:0]    in_vec,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_a,
  output logic                          out_ambig,
  output logic                          out_err
);

  localparam int P  = npairs(WIDTH);
  localparam int KW = cnt_bits(P);
  localparam int JW = cnt_bits(WIDTH);

  icomp_dec_state_e state_q, state_d;
  logic [3*P-1:0]   vec_q, vec_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             a0_known_q, a0_known_d;
  logic             a0_q, a0_d;
  logic             err_q, err_d;

  logic             accept_w;
  logic             step_w;
  logic [KW-1:0]    k_w;
  logic [JW-1:0]    j_w;
  logic [JW-1:0]    i_w;
  logic             last_w;
  logic [2:0]       tri_w;
  logic [2:0]       exp_w;
  logic             onehot_w;
  logic             err_now_w;
  logic [2:0]       tri_arr [P];

  // Split the captured vector into per-pair triples
  for (genvar gi = 0; gi < P; gi++) begin : g_tri
    assign tri_arr[gi] = vec_q[3*gi +: 3];
  end

  assign accept_w = (state_q == IDLE) && in_valid;
  assign step_w   = (state_q == SCAN);

  icomp_pair_walker #(
    .WIDTH (WIDTH),
    .KW    (KW),
    .JW    (JW)
  ) u_walker (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept_w),
    .step  (step_w),
    .k     (k_w),
    .j     (j_w),
    .i     (i_w),
    .last  (last_w)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_err   = (state_q == DONE) && err_q;
  // An error-free vector with A[0] never pinned down can only be all-equal
  assign out_ambig = (state_q == DONE) && !a0_known_q && !err_q;
  assign out_a     = (state_q == DONE) ? (r_q ^ {WIDTH{a0_q}}) : '0;

  // Next-state and per-pair decode/check
  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    r_d        = r_q;
    a0_known_d = a0_known_q;
    a0_d       = a0_q;
    err_d      = err_q;
    err_now_w  = 1'b0;
    tri_w      = tri_arr[k_w];
    onehot_w   = (tri_w == 3'b001) || (tri_w == 3'b010) || (tri_w == 3'b100);
    // j>0 pairs come after every j=0 pair, so r and the polarity are final
    exp_w      = exp_triple(r_q[j_w] ^ a0_q, r_q[i_w] ^ a0_q);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          vec_d      = in_vec;
          r_d        = '0;
          a0_known_d = 1'b0;
          a0_d       = 1'b0;
          err_d      = 1'b0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (!onehot_w) err_now_w = 1'b1;
        if (j_w == '0) begin
          r_d[i_w] = tri_w[TRI_LT] | tri_w[TRI_GT];
          if (onehot_w && !tri_w[TRI_EQ]) begin
            if (a0_known_q) begin
              if (a0_q != tri_w[TRI_GT]) err_now_w = 1'b1;
            end else begin
              a0_known_d = 1'b1;
              a0_d       = tri_w[TRI_GT];
            end
          end
        end else if (tri_w != exp_w) begin
          err_now_w = 1'b1;
        end
        if (err_now_w) err_d = 1'b1;
        if (last_w) state_d = DONE;
`ifdef ICOMP_DEC_EARLY_ABORT_EN
        if (err_now_w) state_d = DONE;
`else
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoder state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      r_q        <= '0;
      a0_known_q <= 1'b0;
      a0_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      r_q        <= r_d;
      a0_known_q <= a0_known_d;
      a0_q       <= a0_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_icomp_decoder.sv
// tb_icomp_decoder: table-driven checks of icomp_decoder at WIDTH=4, plus
// hand-written backpressure and mid-operation reset sequences.
`timescale 1ns/1ps
module tb_icomp_decoder;

  localparam int W  = 4;
  localparam int NP = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3*NP-1:0] in_vec = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_a;
  logic          out_ambig;
  logic          out_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string           name;
    logic [3*NP-1:0] vec;
    logic [W-1:0]    exp_a;
    logic            exp_ambig;
    logic            exp_err;
    int              k_err;   // first failing pair, -1 when the vector is legal
  } vec_t;

  vec_t tbl [10];

  icomp_decoder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_ambig (out_ambig),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // Comparator model: forward direction, builds the vector for word a
  function automatic logic [3*NP-1:0] gen(input logic [W-1:0] a);
    logic [3*NP-1:0] v;
    int k;
    v = '0;
    k = 0;
    for (int j = 0; j < W; j++) begin
      for (int i = j + 1; i < W; i++) begin
        if (a[j] == a[i]) v[3*k +: 3] = 3'b010;
        else if (a[j] < a[i]) v[3*k +: 3] = 3'b001;
        else v[3*k +: 3] = 3'b100;
        k++;
      end
    end
    return v;
  endfunction

  function automatic int exp_lat(input int k_err);
`ifdef ICOMP_DEC_EARLY_ABORT_EN
    return (k_err >= 0) ? k_err + 1 : NP;
`else
    return NP;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t);
    int cyc;
    @(negedge clk);
    in_vec   = t.vec;
    in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({t.name, "_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({t.name, "_accepted"}, {31'd0, in_ready}, 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({t.name, "_latency"}, cyc, exp_lat(t.k_err));
    chk({t.name, "_err"}, {31'd0, out_err}, {31'd0, t.exp_err});
    chk({t.name, "_ambig"}, {31'd0, out_ambig}, {31'd0, t.exp_ambig});
    if (!t.exp_err) chk({t.name, "_a"}, {28'd0, out_a}, {28'd0, t.exp_a});
    $display("vec %s: a=%h ambig=%0d err=%0d latency=%0d", t.name, out_a, out_ambig, out_err, cyc);
    @(posedge clk);
    #1;
    chk({t.name, "_one_cycle"}, {31'd0, out_valid}, 32'd0);
    chk({t.name, "_back_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int cyc;
    logic [3*NP-1:0] v;

    tbl[0] = '{"a1010", gen(4'b1010), 4'hA, 1'b0, 1'b0, -1};
    tbl[1] = '{"a0000", gen(4'b0000), 4'h0, 1'b1, 1'b0, -1};
    tbl[2] = '{"a1111", gen(4'b1111), 4'h0, 1'b1, 1'b0, -1};
    tbl[3] = '{"a0101", gen(4'b0101), 4'h5, 1'b0, 1'b0, -1};
    tbl[4] = '{"a0001", gen(4'b0001), 4'h1, 1'b0, 1'b0, -1};
    tbl[5] = '{"a1000", gen(4'b1000), 4'h8, 1'b0, 1'b0, -1};
    v = gen(4'b0110);
    v[12 +: 3] = 3'b000;
    tbl[6] = '{"corrupt13", v, 4'h0, 1'b0, 1'b1, 4};
    tbl[7] = '{"inconsistent",
               {3'b010, 3'b100, 3'b010, 3'b010, 3'b010, 3'b001}, 4'h0, 1'b0, 1'b1, 3};
    tbl[8] = '{"a0_conflict",
               {3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001}, 4'h0, 1'b0, 1'b1, 1};
    tbl[9] = '{"malformed01",
               {3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b011}, 4'h0, 1'b0, 1'b1, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_a", {28'd0, out_a}, 32'd0);
    chk("rst_ambig", {31'd0, out_ambig}, 32'd0);
    chk("rst_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 10; n++) run_vec(tbl[n]);

    // Backpressure: result held while out_ready is low, new input ignored
    out_ready = 1'b0;
    @(negedge clk);
    in_vec   = gen(4'b1010);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("bp_latency", cyc, NP);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      in_vec   = gen(4'b1111);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_a", {28'd0, out_a}, 32'hA);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    $display("vec backpressure: held a=%h for 10 cycles", out_a);
    out_ready = 1'b1;
    in_vec    = gen(4'b0110);
    @(posedge clk);
    #1;
    chk("bp_release_idle", {31'd0, in_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_next_accepted", {31'd0, in_ready}, 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("bp_next_latency", cyc, NP);
    chk("bp_next_a", {28'd0, out_a}, 32'h6);
    $display("vec after_backpressure: a=%h latency=%0d", out_a, cyc);
    @(posedge clk);
    #1;

    // Reset at k=3 of a scan
    @(negedge clk);
    in_vec   = gen(4'b1010);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("scanrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("scanrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("scanrst_out_a", {28'd0, out_a}, 32'd0);
    chk("scanrst_err", {31'd0, out_err}, 32'd0);
    $display("vec reset_mid_scan: in_ready=%0d out_valid=%0d", in_ready, out_valid);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec('{"after_scan_rst", gen(4'b0110), 4'h6, 1'b0, 1'b0, -1});

    // Reset while a result is held in DONE
    out_ready = 1'b0;
    @(negedge clk);
    in_vec   = gen(4'b0101);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("donerst_pre_a", {28'd0, out_a}, 32'h5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("donerst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("donerst_out_a", {28'd0, out_a}, 32'd0);
    chk("donerst_in_ready", {31'd0, in_ready}, 32'd1);
    $display("vec reset_mid_done: out_valid=%0d out_a=%h", out_valid, out_a);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    run_vec('{"after_done_rst", gen(4'b1110), 4'hE, 1'b0, 1'b0, -1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/icomp_decoder.md
# icomp_decoder

Sequential inverse of the identity comparator. It accepts one packed pairwise-comparison vector (lt/eq/gt triples for every bit pair of a WIDTH-bit word) and walks the pairs one per cycle. It reconstructs the original word, flags the all-equal case where polarity is ambiguous, and flags malformed or self-inconsistent vectors. It sits downstream of the comparator in the benchmark round-trip harness and uses valid/ready handshakes on both sides.

## Interface
- WIDTH, 6, source word width; legal range WIDTH >= 2.
- P (localparam), WIDTH*(WIDTH-1)/2, number of pairs.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  comparison vector present.
- in_ready  output  1  decoder can accept a vector.
- in_vec  input  3*P  packed triples. Pair (j,i), j<i, is ordered j-major then i ascending. Within a triple, bit +0 = A[j]<A[i], +1 = equal, +2 = A[j]>A[i].
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts result.
- out_a  output  WIDTH  reconstructed word.
- out_ambig  output  1  every pair equal; out_a is all-zeros, and all-ones is equally valid.
- out_err  output  1  vector is not a legal comparator output.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready: capture in_vec, clear the working bits, the A0-known flag and err, set pair index k=0, go to SCAN.
- SCAN processes pair k each cycle, in vector order.
  - Any triple that is not one-hot sets err.
  - Pairs with j=0 (k < WIDTH-1):
    - eq gives r[i]=0; lt or gt gives r[i]=1, where r = A xor A[0].
    - lt fixes A0=0 and gt fixes A0=1. A second non-eq pair that implies the opposite A0 sets err.
  - Pairs with j>0: the triple must equal the triple implied by r[j] xor r[i] and the A0 polarity; a mismatch sets err.
  - After the last pair (k=P-1), go to DONE.
- DONE:
  - out_valid=1.
  - out_a = r xor {WIDTH{A0}}. If A0 was never fixed, A0 is taken as 0 and out_ambig=1.
  - Outputs are held stable until out_ready; then go to IDLE.
- out_a content is don't-care when out_err=1, but it must still be deterministic.

## Timing
- Reset values:
  - state=IDLE, in_ready=1.
  - out_valid=0, out_a=0, out_ambig=0, out_err=0.
  - k=0.
- Latency: with the accepting edge at t0, out_valid rises after edge t0+P. For WIDTH=6 this is 15 cycles.
- in_ready is a function of state only (IDLE). It has no combinational path from out_ready.
- DONE->IDLE takes one edge. The next vector can be accepted on the edge after that. Throughput is one vector per P+2 cycles.
- in_valid during SCAN or DONE is ignored and the source holds.
- out_ready=1 already on the first DONE cycle: out_valid is high for exactly one cycle.
- Reset mid-SCAN or mid-DONE: immediate return to IDLE with reset values; the partial result is discarded.
- k is a $clog2(P)-bit counter (minimum 1 bit). It never wraps past P-1.

## Configuration
- ICOMP_DEC_EARLY_ABORT_EN:
  - Defined: the first cycle that sets err moves the FSM to DONE on that same edge, skipping the remaining pairs. Latency becomes k_err+1 cycles.
  - Undefined: all P pairs are always scanned and latency is fixed at P.
- out_err and out_ambig values are identical in both builds. out_a is unspecified on error.

## Structure
- icomp_pkg holds:
  - function npairs(w).
  - triple bit constants TRI_LT=0, TRI_EQ=1, TRI_GT=2.
  - typedef enum icomp_dec_state_e {IDLE, SCAN, DONE}.
  - function exp_triple(bit a, bit b), returning the legal 3-bit triple.
- Sub-module icomp_pair_walker: given step, it produces k, j, i and last, in the j-major order. It resets on rst_n and restarts on start.

## Test plan
- WIDTH=4, vector generated from A=4'b1010, out_ready=1:
  - out_a=4'hA, ambig=0, err=0.
  - out_valid is high exactly 6 cycles after acceptance, for one cycle.
- WIDTH=4, A=4'b0000 vector (all eq):
  - out_a=4'h0, ambig=1, err=0.
  - Same outcome for the A=4'b1111 vector.
- WIDTH=4, A=4'b0110 vector with pair (1,3) triple forced to 3'b000:
  - err=1, ambig=0.
  - Latency 6 without the macro; 5 with ICOMP_DEC_EARLY_ABORT_EN.
- WIDTH=4, all triples legal but inconsistent: (0,1)=lt, (0,2)=eq, (1,2)=eq:
  - err=1.
- Backpressure:
  - out_ready low for 10 cycles: outputs stable, in_ready=0 and a new in_valid is ignored.
  - out_ready is then raised: the next vector is accepted 2 edges later.
- Reset asserted at k=3 of a scan:
  - All outputs return to reset values asynchronously, in_ready=1.
  - The next full vector decodes correctly.
